// File: rtl/bcd2bin_seq_pkg.sv
// Shared constants for the sequential BCD-to-binary converter:
// state encoding and BCD digit thresholds.
package bcd2bin_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX  = 4'd9;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd8;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_VAL    = 4'd3;

endpackage

// File: rtl/bcd2bin_seq_adj.sv
// One BCD digit correction for reverse double-dabble:
// a digit that reached 8 or more after the right shift loses 3.
module bcd_digit_adj
  import bcd2bin_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= ADJ_THRESH) ? (din - ADJ_VAL) : din;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: reverse double-dabble, one bit per
// clock, valid/ready on both sides, error flag for digits above 9.
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] in_bcd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              out_bin,
  output logic                          out_err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  state_t               state;
  logic [BCD_W-1:0]     bcd_work;
  logic [BIN_W-1:0]     bin_work;
  logic [CNT_W-1:0]     step;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_adj;
  logic [DIGITS-1:0]      digit_bad;
  logic                   in_err;

  // The BCD LSB falls into the binary MSB; digits are corrected after the shift.
  assign shifted = {bcd_work, bin_work} >> 1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_adj u_adj (
        .din  (shifted[BIN_W + gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .dout (bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
      assign digit_bad[gi] = in_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > DIGIT_MAX;
    end
  endgenerate

  assign in_err = |digit_bad;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_err   <= 1'b0;
      step      <= '0;
      bcd_work  <= '0;
      bin_work  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            step     <= '0;
            if (in_err) begin
              // out_valid follows one cycle later from DONE
              out_err <= 1'b1;
              out_bin <= '0;
              state   <= DONE;
            end else begin
              out_err  <= 1'b0;
              bcd_work <= in_bcd;
              bin_work <= '0;
              state    <= SHIFT;
            end
          end
        end

        SHIFT: begin
          bcd_work <= bcd_adj;
          bin_work <= shifted[BIN_W-1:0];
          step     <= step + 1'b1;
          if (step == LAST_STEP) begin
            out_bin   <= shifted[BIN_W-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
